// File: rtl/frame_rx_sm.sv
// Receive-side frame assembler: joins two UART bytes (high byte first) into a 16-bit command.
// Define FRM_TIMEOUT_EN to build the inter-byte timeout counter and the frm_err pulse.
module frame_rx_sm #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        ovr,
  output logic        frm_err
);

  typedef enum logic {
    IDLE,
    WAIT_LO
  } state_t;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
    $error("frame_rx_sm: TIMEOUT_CYC must lie in 2..65536");
  end

  state_t      state_q, state_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        ovr_q, ovr_d;
  logic        complete;

  assign clr_rx_rdy = rx_rdy & ~rst;
  assign complete   = (state_q == WAIT_LO) && rx_rdy;

`ifdef FRM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frm_err_q, frm_err_d;
  logic             expire;

  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    ovr_d     = ovr_q;
`ifdef FRM_TIMEOUT_EN
    cnt_d     = cnt_q;
    frm_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          hi_byte_d = rx_data;
          state_d   = WAIT_LO;
`ifdef FRM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d   = {hi_byte_q, rx_data};
          state_d = IDLE;
        end
`ifdef FRM_TIMEOUT_EN
        else if (expire) begin
          hi_byte_d = '0;
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A completing frame outranks a same-cycle acknowledge; the acknowledge still clears ovr.
    if (complete) begin
      cmd_rdy_d = 1'b1;
      if (clr_cmd_rdy) begin
        ovr_d = 1'b0;
      end else if (cmd_rdy_q) begin
        ovr_d = 1'b1;
      end
    end else if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_byte_q <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_byte_q <= hi_byte_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef FRM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      frm_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign frm_err = frm_err_q;
`else
  assign frm_err = 1'b0;
`endif

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign ovr     = ovr_q;

endmodule
